// File: rtl/pry_pkg.sv
// rtl/pry_pkg.sv - shared helpers for the pry arbiter family (one-hot to index, above-pointer mask)
package pry_pkg;

  localparam int PRY_MAX_W = 256;
  localparam int PRY_IDX_W = 8;

  typedef logic [PRY_MAX_W-1:0] pry_vec_t;
  typedef logic [PRY_IDX_W-1:0] pry_idx_t;

  // OR-reduction of set-bit positions; exact for a one-hot or all-zero input.
  function automatic pry_idx_t oht2bin(input pry_vec_t oht);
    pry_idx_t b;
    b = '0;
    for (int i = 0; i < PRY_MAX_W; i++) begin
      if (oht[i]) b = b | i[PRY_IDX_W-1:0];
    end
    return b;
  endfunction

  function automatic pry_vec_t above_mask(input pry_vec_t ptr);
    return ~(ptr | (ptr - pry_vec_t'(1)));
  endfunction

endpackage

// File: rtl/pry2oht_tree.sv
// rtl/pry2oht_tree.sv - lowest-set-bit priority to one-hot tree, SPLIT-ary recursive
module pry2oht_tree #(
  parameter int WIDTH          = 8,
  parameter int SPLIT          = 2,
  parameter int IMPLEMENTATION = 0
) (
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] oht,
  output logic             vld
);

  generate
    if (WIDTH <= SPLIT) begin : g_leaf
      if (IMPLEMENTATION == 0) begin : g_arith
        assign oht = req & (~req + WIDTH'(1));
      end else begin : g_scan
        always_comb begin
          logic found;
          found = 1'b0;
          oht   = '0;
          for (int i = 0; i < WIDTH; i++) begin
            oht[i] = req[i] && !found;
            found  = found | req[i];
          end
        end
      end
      assign vld = |req;
    end else begin : g_node
      localparam int SUB = WIDTH / SPLIT;
      logic [SPLIT-1:0][SUB-1:0] sub_oht;
      logic [SPLIT-1:0]          sub_vld;
      logic [SPLIT-1:0]          grp;

      for (genvar g = 0; g < SPLIT; g++) begin : g_sub
        pry2oht_tree #(
          .WIDTH          (SUB),
          .SPLIT          (SPLIT),
          .IMPLEMENTATION (IMPLEMENTATION)
        ) u_sub (
          .req (req[g*SUB +: SUB]),
          .oht (sub_oht[g]),
          .vld (sub_vld[g])
        );
        assign oht[g*SUB +: SUB] = grp[g] ? sub_oht[g] : '0;
      end

      // Lowest non-empty group wins; only its leaf one-hot is passed through.
      assign grp = sub_vld & (~sub_vld + SPLIT'(1));
      assign vld = |sub_vld;
    end
  endgenerate

endmodule

// File: rtl/pry_arb_rr.sv
// rtl/pry_arb_rr.sv - registered round-robin arbiter with valid/ready grant output
// Optional grant lock enabled by defining PRY_ARB_LOCK_EN.
module pry_arb_rr
  import pry_pkg::*;
#(
  parameter  int WIDTH          = 8,
  parameter  int SPLIT          = 2,
  parameter  int IMPLEMENTATION = 0,
  localparam int WIDTH_LOG      = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     req,
`ifdef PRY_ARB_LOCK_EN
  input  logic                 lck,
`endif
  output logic [WIDTH-1:0]     gnt,
  output logic [WIDTH_LOG-1:0] idx,
  output logic                 vld,
  input  logic                 rdy
);

  logic [WIDTH-1:0]     ptr;
  logic [WIDTH-1:0]     ptr_nxt;
  logic [WIDTH-1:0]     msk;
  logic [WIDTH-1:0]     req_msk;
  logic [WIDTH-1:0]     oht_msk;
  logic [WIDTH-1:0]     oht_all;
  logic [WIDTH-1:0]     sel;
  logic [WIDTH_LOG-1:0] sel_idx;
  logic                 vld_msk;
  logic                 vld_all;
  logic                 xfer;
  logic                 arb;
  logic                 hold;

  assign xfer    = vld && rdy;
  assign arb     = !vld || xfer;
  assign ptr_nxt = xfer ? gnt : ptr;
  assign msk     = WIDTH'(above_mask(pry_vec_t'(ptr_nxt)));
  assign req_msk = req & msk;

  pry2oht_tree #(
    .WIDTH          (WIDTH),
    .SPLIT          (SPLIT),
    .IMPLEMENTATION (IMPLEMENTATION)
  ) u_tree_msk (
    .req (req_msk),
    .oht (oht_msk),
    .vld (vld_msk)
  );

  pry2oht_tree #(
    .WIDTH          (WIDTH),
    .SPLIT          (SPLIT),
    .IMPLEMENTATION (IMPLEMENTATION)
  ) u_tree_all (
    .req (req),
    .oht (oht_all),
    .vld (vld_all)
  );

  // Empty masked search means wrap-around to the lowest requester overall.
  assign sel     = vld_msk ? oht_msk : (vld_all ? oht_all : '0);
  assign sel_idx = WIDTH_LOG'(oht2bin(pry_vec_t'(sel)));

`ifdef PRY_ARB_LOCK_EN
  assign hold = xfer && lck && |(req & gnt);
`else
  assign hold = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt <= '0;
      idx <= '0;
      vld <= 1'b0;
      ptr <= {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      if (xfer && !hold) ptr <= gnt;
      // A locked transfer re-issues the same grant, so the registers simply hold.
      if (arb && !hold) begin
        gnt <= sel;
        idx <= sel_idx;
        vld <= |req;
      end
    end
  end

endmodule

// File: tb/tb_pry_arb_rr.sv
// tb/tb_pry_arb_rr.sv - scoreboard bench for pry_arb_rr against a round-robin reference model
module tb_pry_arb_rr;

  localparam int W  = 8;
  localparam int WL = 3;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  req   = '0;
  logic          rdy   = 1'b0;
  logic [W-1:0]  gnt;
  logic [WL-1:0] idx;
  logic          vld;
`ifdef PRY_ARB_LOCK_EN
  logic          lck   = 1'b0;
`endif

  typedef struct packed {
    logic          v;
    logic [W-1:0]  g;
    logic [WL-1:0] i;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  bit   m_vld  = 1'b0;
  int   m_idx  = 0;
  int   last   = W - 1;

  always #5 clk = ~clk;

  pry_arb_rr #(
    .WIDTH          (W),
    .SPLIT          (2),
    .IMPLEMENTATION (0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
`ifdef PRY_ARB_LOCK_EN
    .lck   (lck),
`endif
    .gnt   (gnt),
    .idx   (idx),
    .vld   (vld),
    .rdy   (rdy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: scan cyclically starting just after the last transferred requester.
  task automatic arbitrate(input logic [W-1:0] r);
    bit found;
    found = 1'b0;
    m_idx = 0;
    m_vld = (r != '0);
    for (int k = 1; k <= W; k++) begin
      int c;
      c = (last + k) % W;
      if (!found && r[c]) begin
        m_idx = c;
        found = 1'b1;
      end
    end
  endtask

  task automatic model(input logic [W-1:0] r, input logic y, input logic l);
    exp_t e;
    bit   locked;
    locked = 1'b0;
    if (m_vld && y) begin
`ifdef PRY_ARB_LOCK_EN
      locked = l && r[m_idx];
`endif
      if (!locked) begin
        last = m_idx;
        arbitrate(r);
      end
    end else if (!m_vld) begin
      arbitrate(r);
    end
    e.v = m_vld;
    e.g = m_vld ? (W'(1) << m_idx) : '0;
    e.i = m_vld ? WL'(m_idx) : '0;
    q.push_back(e);
  endtask

  task automatic step(input logic [W-1:0] r, input logic y, input logic l);
    req = r;
    rdy = y;
`ifdef PRY_ARB_LOCK_EN
    lck = l;
`endif
    @(posedge clk);
    #1;
    model(r, y, l);
  endtask

  task automatic expect_idx(input string name, input int exp);
    chk({name, "_vld"}, 32'(vld), 32'd1);
    chk({name, "_idx"}, 32'(idx), 32'(exp));
  endtask

  task automatic reset_mid();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_vld", 32'(vld), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_idx", 32'(idx), 32'd0);
    m_vld = 1'b0;
    last  = W - 1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb_vld", 32'(vld), 32'(e.v));
        chk("sb_gnt", 32'(gnt), 32'(e.g));
        chk("sb_idx", 32'(idx), 32'(e.i));
      end
    end
  end

  initial begin
    logic [W-1:0] r;
    #12;
    chk("reset_vld", 32'(vld), 32'd0);
    chk("reset_gnt", 32'(gnt), 32'd0);
    chk("reset_idx", 32'(idx), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Sparse requesters with wrap-around.
    step(8'b1010_0100, 1'b1, 1'b0); expect_idx("p1_a", 2);
    step(8'b1010_0100, 1'b1, 1'b0); expect_idx("p1_b", 5);
    step(8'b1010_0100, 1'b1, 1'b0); expect_idx("p1_c", 7);
    step(8'b1010_0100, 1'b1, 1'b0); expect_idx("p1_d", 2);

    // Full rotation from bit 0.
    reset_mid();
    for (int i = 0; i <= W; i++) begin
      step(8'hFF, 1'b1, 1'b0);
      expect_idx("p2", i % W);
    end

    // Stall holds the grant even after its request drops.
    reset_mid();
    step(8'b0001_0010, 1'b0, 1'b0); expect_idx("p3_a", 1);
    step(8'b0001_0010, 1'b0, 1'b0);
    step(8'b0001_0010, 1'b0, 1'b0);
    step(8'b0001_0000, 1'b0, 1'b0);
    chk("p3_hold_gnt", 32'(gnt), 32'h02);
    step(8'b0001_0000, 1'b1, 1'b0); expect_idx("p3_next", 4);

    // Single requester granted every cycle, then idle.
    repeat (3) step(8'b0100_0000, 1'b1, 1'b0);
    expect_idx("p4", 6);
    step(8'h00, 1'b1, 1'b0);
    chk("p4_idle_vld", 32'(vld), 32'd0);
    chk("p4_idle_gnt", 32'(gnt), 32'd0);

    // Asynchronous reset with a pending grant.
    step(8'b0011_0000, 1'b0, 1'b0);
    reset_mid();
    step(8'hFF, 1'b1, 1'b0); expect_idx("p5_first", 0);

`ifdef PRY_ARB_LOCK_EN
    reset_mid();
    step(8'b0000_1001, 1'b1, 1'b1); expect_idx("p6_a", 0);
    step(8'b0000_1001, 1'b1, 1'b1); expect_idx("p6_b", 0);
    step(8'b0000_1001, 1'b1, 1'b1); expect_idx("p6_c", 0);
    step(8'b0000_1001, 1'b1, 1'b0); expect_idx("p6_d", 3);
`endif

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 4))
        0:       r = '0;
        1:       r = W'(1) << $urandom_range(0, W - 1);
        default: r = W'($urandom);
      endcase
      step(r, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0));
      if (n == 200) reset_mid();
    end

    repeat (2) @(negedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pry_arb_rr.md
Name: pry_arb_rr

Overview:
Registered round-robin arbiter that sits directly upstream of the one-hot consumers in the encoder family.
- Arbitration uses two priority-to-one-hot trees: one on masked requests, one on unmasked requests.
- Output is a registered one-hot grant plus its binary index, presented on a valid/ready handshake.
- Provides fair, stall-tolerant selection for shared-resource muxes.

Parameters:
WIDTH, 8, number of requesters; must be a power of SPLIT, minimum 2
SPLIT, 2, tree split factor passed to both internal trees
IMPLEMENTATION, 0, leaf encoder implementation selector passed to the trees
WIDTH_LOG, $clog2(WIDTH), localparam; index width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset; asynchronous assert, active-low
req  input  WIDTH  request vector, one bit per requester
lck  input  1  lock request; present only when PRY_ARB_LOCK_EN is defined
gnt  output  WIDTH  registered one-hot grant; all zeros when vld=0
idx  output  WIDTH_LOG  binary index of gnt; 0 when vld=0
vld  output  1  grant valid
rdy  input  1  downstream accepts grant; transfer = vld && rdy

Behaviour:
- Reset (rst_n=0, asynchronous): gnt=0, idx=0, vld=0, ptr=1<<(WIDTH-1).
  - ptr is the internal one-hot of the last transferred requester.
  - This reset value makes the first search start at bit 0.
- Arbitration enable: arb = !vld || (vld && rdy).
  - When arb=0 (stall), gnt, idx and vld hold their values.
  - A held grant stays stable even if req deasserts.
- Pointer source: ptr_nxt = transfer ? gnt : ptr.
- Search mask: msk = bits strictly above the set bit of ptr_nxt, i.e. ~(ptr_nxt | (ptr_nxt-1)).
- Selection: sel = |(req & msk) ? lowest_one(req & msk) : lowest_one(req).
  - Both terms come from pry2oht_tree instances; their vld outputs drive the choice.
- Register update when arb=1:
  - gnt <= sel
  - idx <= binary(sel)
  - vld <= |req
- Pointer update: ptr <= gnt on transfer; otherwise ptr holds.
- Latency: req rising to vld = 1 cycle.
- Throughput: one grant per cycle with rdy held high.
- Single active requester: granted every cycle (the wrap to the unmasked tree returns the same bit).
- req=0 with arb=1: vld <= 0 and gnt <= 0 on the next edge.
- ptr at bit WIDTH-1: msk=0, so arbitration always uses the unmasked tree (wrap-around).
- rdy is ignored when vld=0.
- Reset mid-stall: the pending grant is dropped; no transfer occurs.
- Idle states are vld=0 and vld=1 stalled. No further FSM; the state is {ptr, gnt, vld}.

Optional Feature:
PRY_ARB_LOCK_EN
- Defined:
  - Port lck exists.
  - If a transfer occurs with lck=1 and req[idx]=1, the next grant is forced to the same requester, bypassing the trees.
  - ptr is not advanced while locked.
  - If req[idx]=0, lck is ignored and normal arbitration proceeds.
- Undefined:
  - No lck port.
  - Pure round-robin as above.

Decomposition:
- Package pry_pkg: helper function oht2bin(WIDTH) for the index, and mask function above_mask(ptr).
- Sub-module: reuse pry2oht_tree for both masked and unmasked selection; no new sub-module.
- Registers and handshake live in pry_arb_rr.

Test Plan:
1. Reset then req=8'b1010_0100, rdy=1 → cycle 1: gnt=0000_0100, idx=2; then idx=5, idx=7, idx=2 (wrap).
2. req=8'b1111_1111, rdy=1 → idx sequence 0,1,2,...,7,0, one grant per cycle.
3. req=8'b0001_0010 with rdy=0 for 3 cycles → gnt=0000_0010 held stable, even after req[1] drops; on rdy=1 the next grant is idx=4.
4. Only req[6]=1, rdy=1 → vld=1, idx=6 every cycle; req drops to 0 → vld=0, gnt=0 the next cycle.
5. Assert rst_n=0 asynchronously mid-cycle while vld=1 → vld, gnt, idx clear immediately; after release the first grant starts the search from bit 0.
6. (PRY_ARB_LOCK_EN) req=8'b0000_1001, lck=1 → idx=0 repeated while lck=1; lck=0 → next grant idx=3.
